csi2_pkt_ctrl: RTL and testbench

- Sits directly downstream of timing_gen.
- Consumes fv/lv plus the pixel bus and buffers active pixels in a store-and-forward line FIFO.
- Emits the CSI-2 packet request sequence to the D-PHY TX wrapper: Frame Start, one long packet per line, Frame End.
- Accepted lines are never partially written; rejected lines and frames raise a sticky overflow flag.

---
 rtl/csi2_pkt_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_csi2_pkt_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_pkt_ctrl.sv
// csi2_pkt_ctrl: buffers timing_gen lines store-and-forward and sequences CSI-2 FS / long packet / FE requests.
// Latency: fv sampled high at N -> sp_en_o at N+2; lv sampled low at N -> lp_en_o at N+2 when the FSM is idle.
// Backpressure: headers hold until hdr_ready_i, payload holds until data_ready_i; lines that cannot fit are dropped and flagged.
// Optional macro CSI2_LINE_PKT_EN wraps every long packet with Line Start / Line End short packets.
module csi2_pkt_ctrl #(
    parameter int         DATA_W         = 16,
    parameter int         MAX_LINE_WORDS = 1920,
    parameter int         FIFO_DEPTH     = 4096,
    parameter int         LINE_Q_DEPTH   = 4,
    parameter logic [5:0] DT             = 6'h1E,
    parameter logic [1:0] VC             = 2'd0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              fv_i,
    input  logic              lv_i,
    input  logic [DATA_W-1:0] pix_i,
    output logic              sp_en_o,
    output logic              lp_en_o,
    output logic [5:0]        dt_o,
    output logic [1:0]        vc_o,
    output logic [15:0]       wc_o,
    input  logic              hdr_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              overflow_o
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int LQ_AW   = $clog2(LINE_Q_DEPTH);
    localparam int BPW     = DATA_W / 8;

    typedef logic [FIFO_AW-1:0] fptr_t;
    typedef logic [FIFO_AW:0]   fcnt_t;
    typedef logic [LQ_AW-1:0]   lqptr_t;
    typedef logic [LQ_AW:0]     lqcnt_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SP_FS, S_SP_LS, S_LP_HDR, S_LP_DATA, S_SP_LE, S_SP_FE
    } state_t;

    // input pipeline and frame/line tracking
    logic              r_fv_q, r_fv_qq, r_lv_q, r_lv_qq;
    logic [DATA_W-1:0] r_pix_q;
    logic              r_armed, r_frame_ok, r_line_act;
    logic [15:0]       r_wcnt;
    logic              r_fs_pend, r_fe_pend, r_ovf;

    // pixel FIFO and line-length queue
    logic [DATA_W-1:0] r_fifo_mem [FIFO_DEPTH];
    fptr_t             r_fifo_wr, r_fifo_rd;
    fcnt_t             r_fifo_cnt;
    logic [15:0]       r_lq_mem [LINE_Q_DEPTH];
    lqptr_t            r_lq_wr, r_lq_rd;
    lqcnt_t            r_lq_cnt;

    // packet FSM registers
    state_t            r_state;
    logic              r_sp_en, r_lp_en, r_dvld;
    logic [5:0]        r_dt;
    logic [15:0]       r_wc, r_rem, r_frame_num;
`ifdef CSI2_LINE_PKT_EN
    logic [15:0]       r_line_num;
`endif

    logic        w_fv_rise, w_fv_fall, w_lv_rise, w_line_end;
    logic        w_lq_full, w_room, w_line_start, w_line_rej;
    logic        w_wr_active, w_wr_en, w_trunc, w_lq_push, w_lq_pop;
    logic        w_pop, w_fs_clr, w_fe_clr, w_lq_nempty;
    logic [15:0] w_cnt_cur, w_lq_head, w_lq_bytes;
    logic [31:0] w_fifo_free;

    // Edges only count once armed; a frame seen rising before arming is never started.
    assign w_fv_rise    = r_armed & r_fv_q & ~r_fv_qq;
    assign w_fv_fall    = r_frame_ok & ~r_fv_q & r_fv_qq;
    assign w_lv_rise    = r_frame_ok & r_fv_q & r_lv_q & ~r_lv_qq;
    assign w_line_end   = r_line_act & ~(r_lv_q & r_fv_q);

    // A line is admitted only if a worst-case line fits, so it is never half-written.
    assign w_fifo_free  = FIFO_DEPTH - 32'(r_fifo_cnt);
    assign w_lq_full    = (32'(r_lq_cnt) == LINE_Q_DEPTH);
    assign w_room       = ~w_lq_full & (w_fifo_free >= MAX_LINE_WORDS);
    assign w_line_start = w_lv_rise & w_room;
    assign w_line_rej   = w_lv_rise & ~w_room;

    assign w_wr_active  = w_line_start | (r_line_act & r_lv_q & r_fv_q);
    assign w_cnt_cur    = w_line_start ? 16'd0 : r_wcnt;
    assign w_wr_en      = w_wr_active & (w_cnt_cur < 16'(MAX_LINE_WORDS));
    assign w_trunc      = w_wr_active & ~(w_cnt_cur < 16'(MAX_LINE_WORDS));
    assign w_lq_push    = w_line_end & (r_wcnt != 16'd0);

    assign w_pop        = r_dvld & data_ready_i;
    assign w_lq_nempty  = (r_lq_cnt != '0);
    assign w_lq_head    = r_lq_mem[r_lq_rd];
    assign w_lq_bytes   = w_lq_head * 16'(BPW);
    assign w_lq_pop     = (r_state == S_LP_DATA) & w_pop & (r_rem == 16'd1);
    assign w_fs_clr     = (r_state == S_SP_FS) & hdr_ready_i;
    assign w_fe_clr     = (r_state == S_SP_FE) & hdr_ready_i;

    assign sp_en_o      = r_sp_en;
    assign lp_en_o      = r_lp_en;
    assign dt_o         = r_dt;
    assign vc_o         = VC;
    assign wc_o         = r_wc;
    assign data_valid_o = r_dvld;
    assign data_o       = r_dvld ? r_fifo_mem[r_fifo_rd] : '0;
    assign overflow_o   = r_ovf;

    // Input sampling, arming, frame acceptance, line word counting and sticky overflow.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_fv_q     <= 1'b0;
            r_fv_qq    <= 1'b0;
            r_lv_q     <= 1'b0;
            r_lv_qq    <= 1'b0;
            r_pix_q    <= '0;
            r_armed    <= 1'b0;
            r_frame_ok <= 1'b0;
            r_line_act <= 1'b0;
            r_wcnt     <= '0;
            r_fs_pend  <= 1'b0;
            r_fe_pend  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_fv_q  <= fv_i;
            r_fv_qq <= r_fv_q;
            r_lv_q  <= lv_i;
            r_lv_qq <= r_lv_q;
            r_pix_q <= pix_i;
            if (!fv_i)
                r_armed <= 1'b1;
            if (w_fs_clr)
                r_fs_pend <= 1'b0;
            if (w_fe_clr)
                r_fe_pend <= 1'b0;
            // A new frame while the previous FS/FE is still owed is dropped whole.
            if (w_fv_rise) begin
                if (r_fs_pend || r_fe_pend) begin
                    r_frame_ok <= 1'b0;
                    r_ovf      <= 1'b1;
                end else begin
                    r_frame_ok <= 1'b1;
                    r_fs_pend  <= 1'b1;
                end
            end
            if (w_fv_fall) begin
                r_frame_ok <= 1'b0;
                r_fe_pend  <= 1'b1;
            end
            if (w_line_start)
                r_line_act <= 1'b1;
            else if (w_line_end)
                r_line_act <= 1'b0;
            if (w_wr_en)
                r_wcnt <= w_cnt_cur + 16'd1;
            if (w_line_rej || w_trunc)
                r_ovf <= 1'b1;
        end
    end

    // Pixel FIFO storage.
    always_ff @(posedge sys_clk) begin
        if (w_wr_en)
            r_fifo_mem[r_fifo_wr] <= r_pix_q;
    end

    // Pixel FIFO pointers and occupancy.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_wr_en)
                r_fifo_wr <= r_fifo_wr + fptr_t'(1);
            if (w_pop)
                r_fifo_rd <= r_fifo_rd + fptr_t'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + fcnt_t'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - fcnt_t'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Completed-line length storage.
    always_ff @(posedge sys_clk) begin
        if (w_lq_push)
            r_lq_mem[r_lq_wr] <= r_wcnt;
    end

    // Line queue pointers and occupancy.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_lq_wr  <= '0;
            r_lq_rd  <= '0;
            r_lq_cnt <= '0;
        end else begin
            if (w_lq_push)
                r_lq_wr <= r_lq_wr + lqptr_t'(1);
            if (w_lq_pop)
                r_lq_rd <= r_lq_rd + lqptr_t'(1);
            case ({w_lq_push, w_lq_pop})
                2'b10:   r_lq_cnt <= r_lq_cnt + lqcnt_t'(1);
                2'b01:   r_lq_cnt <= r_lq_cnt - lqcnt_t'(1);
                default: r_lq_cnt <= r_lq_cnt;
            endcase
        end
    end

    // Packet sequencer: FS first, then queued lines, FE only once the frame is fully drained.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_sp_en     <= 1'b0;
            r_lp_en     <= 1'b0;
            r_dt        <= '0;
            r_wc        <= '0;
            r_dvld      <= 1'b0;
            r_rem       <= '0;
            r_frame_num <= 16'd1;
`ifdef CSI2_LINE_PKT_EN
            r_line_num  <= 16'd1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_fs_pend) begin
                        r_state <= S_SP_FS;
                        r_sp_en <= 1'b1;
                        r_dt    <= 6'h00;
                        r_wc    <= r_frame_num;
                    end else if (w_lq_nempty) begin
`ifdef CSI2_LINE_PKT_EN
                        r_state <= S_SP_LS;
                        r_sp_en <= 1'b1;
                        r_dt    <= 6'h02;
                        r_wc    <= r_line_num;
`else
                        r_state <= S_LP_HDR;
                        r_lp_en <= 1'b1;
                        r_dt    <= DT;
                        r_wc    <= w_lq_bytes;
`endif
                    end else if (r_fe_pend && !r_line_act) begin
                        r_state <= S_SP_FE;
                        r_sp_en <= 1'b1;
                        r_dt    <= 6'h01;
                        r_wc    <= r_frame_num;
                    end
                end
                S_SP_FS: begin
                    if (hdr_ready_i) begin
                        r_state <= S_IDLE;
                        r_sp_en <= 1'b0;
                        r_dt    <= '0;
                        r_wc    <= '0;
`ifdef CSI2_LINE_PKT_EN
                        r_line_num <= 16'd1;
`endif
                    end
                end
`ifdef CSI2_LINE_PKT_EN
                S_SP_LS: begin
                    if (hdr_ready_i) begin
                        r_state <= S_LP_HDR;
                        r_sp_en <= 1'b0;
                        r_lp_en <= 1'b1;
                        r_dt    <= DT;
                        r_wc    <= w_lq_bytes;
                    end
                end
                S_SP_LE: begin
                    if (hdr_ready_i) begin
                        r_state    <= S_IDLE;
                        r_sp_en    <= 1'b0;
                        r_dt       <= '0;
                        r_wc       <= '0;
                        r_line_num <= r_line_num + 16'd1;
                    end
                end
`endif
                S_LP_HDR: begin
                    if (hdr_ready_i) begin
                        r_state <= S_LP_DATA;
                        r_lp_en <= 1'b0;
                        r_dt    <= '0;
                        r_wc    <= '0;
                        r_dvld  <= 1'b1;
                        r_rem   <= w_lq_head;
                    end
                end
                S_LP_DATA: begin
                    if (w_pop) begin
                        r_rem <= r_rem - 16'd1;
                        if (r_rem == 16'd1) begin
                            r_dvld  <= 1'b0;
`ifdef CSI2_LINE_PKT_EN
                            r_state <= S_SP_LE;
                            r_sp_en <= 1'b1;
                            r_dt    <= 6'h03;
                            r_wc    <= r_line_num;
`else
                            r_state <= S_IDLE;
`endif
                        end
                    end
                end
                S_SP_FE: begin
                    if (hdr_ready_i) begin
                        r_state     <= S_IDLE;
                        r_sp_en     <= 1'b0;
                        r_dt        <= '0;
                        r_wc        <= '0;
                        r_frame_num <= (r_frame_num == 16'hFFFF) ? 16'd1 : r_frame_num + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// tb_csi2_pkt_ctrl: directed frames with a scoreboard of expected FS/LS/LP/data/LE/FE events.
// The monitor pops one expected event per header or payload handshake and checks hold-stability while stalled.
module tb_csi2_pkt_ctrl;

    localparam int MAXW = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        fv_i = 1'b0;
    logic        lv_i = 1'b0;
    logic [15:0] pix_i = '0;
    logic        hdr_ready_i = 1'b1;
    logic        data_ready_i = 1'b1;
    logic        sp_en_o, lp_en_o, data_valid_o, overflow_o;
    logic [5:0]  dt_o;
    logic [1:0]  vc_o;
    logic [15:0] wc_o, data_o;

    always #5 sys_clk = ~sys_clk;

    csi2_pkt_ctrl #(
        .DATA_W(16), .MAX_LINE_WORDS(MAXW), .FIFO_DEPTH(16), .LINE_Q_DEPTH(2),
        .DT(6'h1E), .VC(2'd0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fv_i(fv_i), .lv_i(lv_i), .pix_i(pix_i),
        .sp_en_o(sp_en_o), .lp_en_o(lp_en_o), .dt_o(dt_o), .vc_o(vc_o), .wc_o(wc_o),
        .hdr_ready_i(hdr_ready_i), .data_o(data_o), .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i), .overflow_o(overflow_o)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 short, 1 long header, 2 payload word
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [15:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          hdr_mode = 0;   // 0 tied high, 1 grant after 5 cycles, 2 held low
    int          dr_mode  = 0;   // 0 tied high, 1 toggling
    bit          saw_req = 1'b0;
    logic [15:0] frame_no = 16'd1;
    logic [15:0] line_no  = 16'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push_e(input logic [1:0] kind, input logic [5:0] dt,
                                   input logic [15:0] wc, input logic [15:0] dat);
        exp_t e;
        e.kind = kind; e.dt = dt; e.wc = wc; e.dat = dat;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    // Expected packets for one accepted line, truncated to MAXW words.
    task automatic push_line(input int n, input int base);
        int k;
        k = (n > MAXW) ? MAXW : n;
`ifdef CSI2_LINE_PKT_EN
        push_e(2'd0, 6'h02, line_no, 16'h0);
`endif
        push_e(2'd1, 6'h1E, 16'(k * 2), 16'h0);
        for (int i = 0; i < k; i++)
            push_e(2'd2, 6'h0, 16'h0, 16'(base + i));
`ifdef CSI2_LINE_PKT_EN
        push_e(2'd0, 6'h03, line_no, 16'h0);
        line_no = line_no + 16'd1;
`endif
    endtask

    task automatic frame_start();
        fv_i = 1'b1;
        push_e(2'd0, 6'h00, frame_no, 16'h0);
        line_no = 16'd1;
    endtask

    task automatic push_fe();
        push_e(2'd0, 6'h01, frame_no, 16'h0);
        frame_no = (frame_no == 16'hFFFF) ? 16'd1 : frame_no + 16'd1;
    endtask

    task automatic frame_end();
        fv_i = 1'b0;
        push_fe();
        tick();
    endtask

    // Drive one line; 'last' drops fv in the same cycle as lv.
    task automatic send_line(input int n, input int base, input bit accept, input bit last);
        if (accept)
            push_line(n, base);
        lv_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_i = 16'(base + i);
            tick();
        end
        lv_i  = 1'b0;
        pix_i = '0;
        if (last) begin
            fv_i = 1'b0;
            push_fe();
        end
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Ready generators for the PHY side.
    initial begin
        int dly;
        dly = 0;
        forever begin
            tick();
            case (hdr_mode)
                0: hdr_ready_i = 1'b1;
                1: begin
                    if (hdr_ready_i) begin
                        hdr_ready_i = 1'b0;
                        dly = 0;
                    end else if (sp_en_o || lp_en_o) begin
                        dly++;
                        if (dly >= 5) hdr_ready_i = 1'b1;
                    end else begin
                        dly = 0;
                    end
                end
                default: hdr_ready_i = 1'b0;
            endcase
            data_ready_i = (dr_mode == 1) ? ~data_ready_i : 1'b1;
        end
    end

    // Monitor: scoreboard pops on handshakes, stability while stalled.
    initial begin
        bit          p_hdr, p_dat, p_sp, p_lp;
        logic [5:0]  p_dt;
        logic [15:0] p_wc, p_data;
        exp_t        e;
        p_hdr = 0; p_dat = 0; p_sp = 0; p_lp = 0; p_dt = '0; p_wc = '0; p_data = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                p_hdr = 0;
                p_dat = 0;
            end else begin
                if (sp_en_o || lp_en_o) saw_req = 1'b1;
                if (sp_en_o && lp_en_o)
                    chk("sp_lp_exclusive", {sp_en_o, lp_en_o}, 2'b10);
                if (p_hdr) begin
                    chk("hdr_hold_en", {sp_en_o, lp_en_o}, {p_sp, p_lp});
                    chk("hdr_hold_dt", dt_o, p_dt);
                    chk("hdr_hold_wc", wc_o, p_wc);
                end
                if (p_dat) begin
                    chk("data_hold_vld", data_valid_o, 1);
                    chk("data_hold_dat", data_o, p_data);
                end
                if ((sp_en_o || lp_en_o) && hdr_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_hdr: got dt 0x%0h wc 0x%0h, expected no packet", dt_o, wc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hdr_kind", lp_en_o ? 2'd1 : 2'd0, e.kind);
                        chk("hdr_dt", dt_o, e.dt);
                        chk("hdr_wc", wc_o, e.wc);
                        chk("hdr_vc", vc_o, 2'd0);
                    end
                end
                if (data_valid_o && data_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_data: got 0x%0h, expected no payload", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_kind", 2'd2, e.kind);
                        chk("data_word", data_o, e.dat);
                    end
                end
                p_hdr  = (sp_en_o || lp_en_o) && !hdr_ready_i;
                p_sp   = sp_en_o;
                p_lp   = lp_en_o;
                p_dt   = dt_o;
                p_wc   = wc_o;
                p_dat  = data_valid_o && !data_ready_i;
                p_data = data_o;
            end
        end
    end

    initial begin
        // Reset with fv high, outputs must be idle.
        fv_i = 1'b1;
        gap(3);
        chk("rst_outs", {sp_en_o, lp_en_o, dt_o, vc_o, wc_o, data_valid_o, overflow_o}, 0);
        chk("rst_data", data_o, 0);

        // Release mid-frame: nothing may be emitted for this partial frame.
        sys_rst = 1'b0;
        gap(2);
        send_line(5, 16'h0A00, 1'b0, 1'b0);
        gap(3);
        send_line(5, 16'h0A10, 1'b0, 1'b0);
        gap(6);
        fv_i = 1'b0;
        gap(6);
        chk("no_pkt_after_rst", saw_req, 0);

        // Frame 1: 3 x 8 words, readies high; FS two cycles after fv is sampled.
        frame_start();
        gap(2);
        chk("fs_latency_early", sp_en_o, 0);
        tick();
        chk("fs_latency", sp_en_o, 1);
        gap(2);
        send_line(8, 16'h0100, 1'b1, 1'b0);
        gap(12);
        send_line(8, 16'h0110, 1'b1, 1'b0);
        gap(12);
        send_line(8, 16'h0120, 1'b1, 1'b0);
        gap(12);
        frame_end();
        wait_drain("drain_f1", 200);
        chk("ovf_clean", overflow_o, 0);

        // Frame 2: delayed header grant and toggling payload ready.
        hdr_mode = 1;
        dr_mode  = 1;
        frame_start();
        gap(4);
        send_line(8, 16'h0200, 1'b1, 1'b0);
        gap(30);
        send_line(8, 16'h0210, 1'b1, 1'b0);
        gap(4);
        frame_end();
        wait_drain("drain_f2", 400);
        hdr_mode = 0;
        dr_mode  = 0;
        gap(4);
        chk("ovf_still_clean", overflow_o, 0);

        // Frame 3: truncated 12-word line, then a full line queue drops the third short line.
        frame_start();
        gap(4);
        send_line(12, 16'h0300, 1'b1, 1'b0);
        wait_drain("drain_trunc", 100);
        chk("ovf_trunc", overflow_o, 1);
        hdr_mode = 2;
        gap(2);
        send_line(4, 16'h0320, 1'b1, 1'b0);
        gap(2);
        send_line(4, 16'h0330, 1'b1, 1'b0);
        gap(2);
        send_line(4, 16'h0340, 1'b0, 1'b0);
        gap(5);
        hdr_mode = 0;
        gap(2);
        frame_end();
        wait_drain("drain_f3", 200);
        chk("ovf_sticky", overflow_o, 1);

        // Frame 4: frame number at 0xFFFF, fv and lv fall together.
        force dut.r_frame_num = 16'hFFFF;
        tick();
        release dut.r_frame_num;
        frame_no = 16'hFFFF;
        frame_start();
        gap(4);
        send_line(8, 16'h0400, 1'b1, 1'b0);
        gap(12);
        send_line(6, 16'h0410, 1'b1, 1'b1);
        wait_drain("drain_f4", 200);

        // Frame 5: number wraps to 1.
        gap(4);
        frame_start();
        gap(4);
        send_line(4, 16'h0500, 1'b1, 1'b0);
        gap(4);
        frame_end();
        wait_drain("drain_f5", 200);
        chk("ovf_until_reset", overflow_o, 1);

        // Reset clears the sticky flag.
        sys_rst = 1'b1;
        gap(2);
        chk("ovf_after_reset", overflow_o, 0);
        chk("idle_after_reset", {sp_en_o, lp_en_o, data_valid_o}, 0);
        sys_rst = 1'b0;
        gap(2);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
